// File: rtl/monster_formation_motion.sv
// Invader formation motion controller.
// Steps the formation horizontally once per frame. When a side edge is hit it drops by a fixed
// step and reverses direction. It also counts missile-hit frames and reports when the game has
// ended (landed, or touched the player/shield) and when the formation has been cleared.
// Optional feature macro: MONSTER_SPEEDUP_EN. When it is defined, |Xspeed| grows on every
// reversal, up to MAX_X_SPEED.
module monster_formation_motion #(
  parameter int INITIAL_X      = 60,
  parameter int INITIAL_Y      = 20,
  parameter int X_SPEED        = 30,
  parameter int OBJECT_WIDTH_X = 512,
  parameter int OBJECT_HIGHT_Y = 256,
  parameter int SAFETY_MARGIN  = 2,
  parameter int DROP_STEP      = 8,
  parameter int SPEEDUP        = 8,
  parameter int MAX_X_SPEED    = 256,
  parameter int BOTTOM_LINE    = 440,
  parameter int HITS_TO_CLEAR  = 32,
  parameter int FP_SHIFT       = 6
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               restart,
  input  logic               collisionPlayer,
  input  logic               collisionShield,
  input  logic               collisionMissile,
  input  logic               collisionBorder,
  input  logic [3:0]         HitEdgeCode,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic [7:0]         hitCount,
  output logic               endGame,
  output logic               formationCleared
);

  typedef enum logic [2:0] {
    StIdle,
    StMove,
    StStartOfFrame,
    StPositionChange,
    StPositionLimits,
    StEndGame,
    StCleared
  } state_e;

  // Fixed-point start position and horizontal clamp window.
  localparam logic signed [31:0] XStart = INITIAL_X << FP_SHIFT;
  localparam logic signed [31:0] YStart = INITIAL_Y << FP_SHIFT;
  localparam logic signed [31:0] XMin   = SAFETY_MARGIN << FP_SHIFT;
  localparam logic signed [31:0] XMax   = (639 - SAFETY_MARGIN - OBJECT_WIDTH_X) << FP_SHIFT;
  localparam logic [7:0]         HitsClear = 8'(HITS_TO_CLEAR);

  state_e state_q, state_d;

  logic signed [31:0] x_pos_q, x_pos_d;
  logic signed [31:0] y_pos_q, y_pos_d;
  logic signed [31:0] x_speed_q, x_speed_d;
  logic signed [31:0] drop_q, drop_d;
  logic [7:0]         hit_count_q, hit_count_d;
  logic               player_flag_q, player_flag_d;
  logic               missile_flag_q, missile_flag_d;
  logic [3:0]         edge_q, edge_d;

  logic [7:0]         hit_inc;
  logic               ended_now;
  logic               cleared_now;
  logic               reverse_now;
  logic               landed;
  logic               latch_en;
  logic signed [31:0] speed_rev;

  assign hit_inc     = (hit_count_q == 8'hFF) ? 8'hFF : hit_count_q + 8'd1;
  assign ended_now   = player_flag_q || edge_q[0];
  assign cleared_now = missile_flag_q && (hit_inc == HitsClear);
  // Reverse only when the touched side lies ahead of the motion; both sides touched is ambiguous.
  assign reverse_now = ((edge_q[3] && (x_speed_q < 0)) || (edge_q[1] && (x_speed_q > 0))) &&
                       !(edge_q[3] && edge_q[1]);
  assign landed      = ((y_pos_q >>> FP_SHIFT) + OBJECT_HIGHT_Y) >= BOTTOM_LINE;
  assign latch_en    = (state_q == StMove) || (state_q == StPositionChange) ||
                       (state_q == StPositionLimits);

`ifdef MONSTER_SPEEDUP_EN
  logic signed [31:0] speed_abs;
  logic signed [31:0] speed_abs_up;

  // Reversed speed with magnitude increased and saturated.
  always_comb begin
    speed_abs    = (x_speed_q < 0) ? -x_speed_q : x_speed_q;
    speed_abs_up = speed_abs + SPEEDUP;
    if (speed_abs_up > MAX_X_SPEED) begin
      speed_abs_up = MAX_X_SPEED;
    end
    speed_rev = (x_speed_q < 0) ? speed_abs_up : -speed_abs_up;
  end
`else
  assign speed_rev = -x_speed_q;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q        <= StIdle;
      x_pos_q        <= '0;
      y_pos_q        <= '0;
      x_speed_q      <= '0;
      drop_q         <= '0;
      hit_count_q    <= '0;
      player_flag_q  <= 1'b0;
      missile_flag_q <= 1'b0;
      edge_q         <= '0;
    end else begin
      state_q        <= state_d;
      x_pos_q        <= x_pos_d;
      y_pos_q        <= y_pos_d;
      x_speed_q      <= x_speed_d;
      drop_q         <= drop_d;
      hit_count_q    <= hit_count_d;
      player_flag_q  <= player_flag_d;
      missile_flag_q <= missile_flag_d;
      edge_q         <= edge_d;
    end
  end

  // Next-state logic; restart overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:           if (startOfFrame) state_d = StMove;
      StMove:           if (startOfFrame) state_d = StStartOfFrame;
      StStartOfFrame: begin
        if (ended_now) begin
          state_d = StEndGame;
        end else if (cleared_now) begin
          state_d = StCleared;
        end else begin
          state_d = StPositionChange;
        end
      end
      StPositionChange: state_d = StPositionLimits;
      StPositionLimits: state_d = landed ? StEndGame : StMove;
      StEndGame:        state_d = StEndGame;
      StCleared:        state_d = StCleared;
      default:          state_d = StIdle;
    endcase
    if (restart) begin
      state_d = StIdle;
    end
  end

  // Datapath next values: collision latching, per-frame decisions and position update.
  always_comb begin
    x_pos_d        = x_pos_q;
    y_pos_d        = y_pos_q;
    x_speed_d      = x_speed_q;
    drop_d         = drop_q;
    hit_count_d    = hit_count_q;
    player_flag_d  = player_flag_q;
    missile_flag_d = missile_flag_q;
    edge_d         = edge_q;

    if (latch_en) begin
      player_flag_d  = player_flag_q | collisionPlayer | collisionShield;
      missile_flag_d = missile_flag_q | collisionMissile;
      if (collisionBorder) begin
        edge_d = edge_q | HitEdgeCode;
      end
    end

    case (state_q)
      StIdle: begin
        x_pos_d        = XStart;
        y_pos_d        = YStart;
        x_speed_d      = X_SPEED;
        drop_d         = '0;
        hit_count_d    = '0;
        player_flag_d  = 1'b0;
        missile_flag_d = 1'b0;
        edge_d         = '0;
      end
      StStartOfFrame: begin
        player_flag_d  = 1'b0;
        missile_flag_d = 1'b0;
        edge_d         = '0;
        if (!ended_now) begin
          if (missile_flag_q) begin
            hit_count_d = hit_inc;
          end
          if (!cleared_now && reverse_now) begin
            x_speed_d = speed_rev;
            drop_d    = DROP_STEP;
          end
        end
      end
      StPositionChange: begin
        x_pos_d = x_pos_q + x_speed_q;
        y_pos_d = y_pos_q + (drop_q <<< FP_SHIFT);
        drop_d  = '0;
      end
      StPositionLimits: begin
        if (x_pos_q < XMin) begin
          x_pos_d = XMin;
        end else if (x_pos_q > XMax) begin
          x_pos_d = XMax;
        end
      end
      default: ;
    endcase
  end

  // Outputs: pixel position by arithmetic shift, status levels decoded from state.
  always_comb begin
    topLeftX         = 11'(x_pos_q >>> FP_SHIFT);
    topLeftY         = 11'(y_pos_q >>> FP_SHIFT);
    hitCount         = hit_count_q;
    endGame          = (state_q == StEndGame);
    formationCleared = (state_q == StCleared);
  end

endmodule

// File: tb/tb_monster_formation_motion.sv
// Scoreboard bench for monster_formation_motion: a frame-level model pushes expected outputs
// when a frame is driven; they are popped and compared once the frame has settled.
module tb_monster_formation_motion;

  logic               clk;
  logic               resetN;
  logic               startOfFrame;
  logic               restart;
  logic               collisionPlayer;
  logic               collisionShield;
  logic               collisionMissile;
  logic               collisionBorder;
  logic [3:0]         HitEdgeCode;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic [7:0]         hitCount;
  logic               endGame;
  logic               formationCleared;

  monster_formation_motion dut (
    .clk              (clk),
    .resetN           (resetN),
    .startOfFrame     (startOfFrame),
    .restart          (restart),
    .collisionPlayer  (collisionPlayer),
    .collisionShield  (collisionShield),
    .collisionMissile (collisionMissile),
    .collisionBorder  (collisionBorder),
    .HitEdgeCode      (HitEdgeCode),
    .topLeftX         (topLeftX),
    .topLeftY         (topLeftY),
    .hitCount         (hitCount),
    .endGame          (endGame),
    .formationCleared (formationCleared)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string tag;
    int    kind;
    int    value;
  } exp_t;

  exp_t sb[$];

  // Frame-level reference model (fixed point, 1/64 pixel).
  int  m_x, m_y, m_spd, m_hit;
  bit  m_end, m_clr;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_x = 60 * 64; m_y = 20 * 64; m_spd = 30; m_hit = 0; m_end = 0; m_clr = 0;
  endtask

  task automatic model_frame(input bit pl, input bit mi, input logic [3:0] edg);
    int drop;
    int mag;
    if (m_end || m_clr) return;
    if (pl || edg[0]) begin
      m_end = 1;
      return;
    end
    if (mi) begin
      if (m_hit < 255) m_hit++;
      if (m_hit == 32) begin
        m_clr = 1;
        return;
      end
    end
    drop = 0;
    if (((edg[3] && m_spd < 0) || (edg[1] && m_spd > 0)) && !(edg[3] && edg[1])) begin
      mag = (m_spd < 0) ? -m_spd : m_spd;
`ifdef MONSTER_SPEEDUP_EN
      mag = mag + 8;
      if (mag > 256) mag = 256;
`endif
      m_spd = (m_spd < 0) ? mag : -mag;
      drop = 8;
    end
    m_x = m_x + m_spd;
    m_y = m_y + drop * 64;
    if (m_x < 2 * 64) m_x = 2 * 64;
    else if (m_x > 125 * 64) m_x = 125 * 64;
    if ((m_y >>> 6) + 256 >= 440) m_end = 1;
  endtask

  task automatic push_expect(input string tag);
    sb.push_back('{tag: {tag, "_x"},   kind: 0, value: m_x >>> 6});
    sb.push_back('{tag: {tag, "_y"},   kind: 1, value: m_y >>> 6});
    sb.push_back('{tag: {tag, "_hit"}, kind: 2, value: m_hit});
    sb.push_back('{tag: {tag, "_end"}, kind: 3, value: int'(m_end)});
    sb.push_back('{tag: {tag, "_clr"}, kind: 4, value: int'(m_clr)});
  endtask

  task automatic drain();
    exp_t e;
    int   got;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        0:       got = int'(topLeftX);
        1:       got = int'(topLeftY);
        2:       got = int'(hitCount);
        3:       got = int'(endGame);
        default: got = int'(formationCleared);
      endcase
      check(e.tag, got, e.value);
    end
  endtask

  task automatic pulse_sof();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  // Restart to IDLE, let IDLE load, then leave IDLE into MOVE.
  task automatic do_restart(input string tag);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    tick();
    model_reset();
    push_expect(tag);
    drain();
    pulse_sof();
  endtask

  // One frame: collisions driven in MOVE, then startOfFrame and settle through LIMITS.
  task automatic do_frame(input string tag, input bit pl, input bit sh, input int n_mis,
                          input logic [3:0] code);
    model_frame(pl | sh, n_mis > 0, code);
    push_expect(tag);
    collisionPlayer = pl;
    collisionShield = sh;
    collisionBorder = (code != 4'b0);
    HitEdgeCode     = code;
    tick();
    collisionPlayer = 1'b0;
    collisionShield = 1'b0;
    collisionBorder = 1'b0;
    HitEdgeCode     = 4'b0;
    for (int i = 0; i < n_mis; i++) begin
      collisionMissile = 1'b1;
      tick();
      collisionMissile = 1'b0;
      tick();
    end
    pulse_sof();
    tick();
    tick();
    tick();
    drain();
  endtask

  initial begin
    int frames;
    resetN = 1'b0; startOfFrame = 1'b0; restart = 1'b0;
    collisionPlayer = 1'b0; collisionShield = 1'b0; collisionMissile = 1'b0;
    collisionBorder = 1'b0; HitEdgeCode = 4'b0;
    #1;
    m_x = 0; m_y = 0; m_spd = 0; m_hit = 0; m_end = 0; m_clr = 0;
    push_expect("rst");
    drain();
    @(posedge clk);
    #1;
    resetN = 1'b1;

    // 1: free motion, three frames.
    do_restart("t1_idle");
    for (int i = 0; i < 3; i++) do_frame("t1", 0, 0, 0, 4'b0);
    check("t1_x61", int'(topLeftX), 61);

    // 2: right border reversal with drop.
    do_restart("t2_idle");
    do_frame("t2a", 0, 0, 0, 4'b0);
    do_frame("t2b", 0, 0, 0, 4'b0);
    do_frame("t2_rev", 0, 0, 0, 4'b0010);
    check("t2_y28", int'(topLeftY), 28);
    do_frame("t2_after", 0, 0, 0, 4'b0);

    // 3: shield contact ends the game one clock after START_OF_FRAME.
    do_restart("t3_idle");
    model_frame(1, 0, 4'b0);
    push_expect("t3_sof1");
    collisionShield = 1'b1;
    tick();
    collisionShield = 1'b0;
    pulse_sof();
    tick();
    drain();
    for (int i = 0; i < 10; i++) do_frame("t3_frz", 0, 0, 2, 4'b0010);
    do_restart("t3_rst");
    check("t3_end0", int'(endGame), 0);

    // 4: clear the formation with 32 hit frames, then collisions are ignored.
    for (int i = 0; i < 32; i++) do_frame("t4", 0, 0, 3, 4'b0);
    check("t4_hit32", int'(hitCount), 32);
    do_frame("t4_ign", 1, 0, 2, 4'b0001);

    // 5: zig-zag down until landed.
    do_restart("t5_idle");
    frames = 0;
    while (frames < 40) begin
      do_frame("t5", 0, 0, 0, (m_spd > 0) ? 4'b0010 : 4'b1000);
      frames++;
      if (endGame) break;
    end
    check("t5_frames", frames, 21);
    check("t5_y188", int'(topLeftY), 188);
    for (int i = 0; i < 3; i++) do_frame("t5_frz", 0, 0, 0, 4'b0);

    // 6: asynchronous reset in the middle of POSITION_CHANGE.
    do_restart("t6_idle");
    for (int i = 0; i < 5; i++) do_frame("t6", 0, 0, 1, 4'b0);
    pulse_sof();
    tick();
    resetN = 1'b0;
    #1;
    m_x = 0; m_y = 0; m_hit = 0; m_end = 0; m_clr = 0;
    push_expect("t6_async");
    drain();
    @(posedge clk);
    #1;
    resetN = 1'b1;
    tick();
    model_reset();
    pulse_sof();
    do_frame("t6_post", 0, 0, 0, 4'b0);

    // 7: drift into the right clamp.
    do_restart("t7_idle");
    for (int i = 0; i < 150; i++) do_frame("t7", 0, 0, 0, 4'b0);
    check("t7_xmax", int'(topLeftX), 125);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/monster_formation_motion.md
Name: monster_formation_motion

Overview:
- Parametrised next-generation motion controller for the invader formation sprite block.
- Moves the formation horizontally each frame. On reaching a side edge it drops by a fixed step, reverses direction and optionally speeds up.
- Counts missile hits, detects landing and player/shield contact, and reports game-end and cleared status to the game controller.
- Sits between the VGA collision detectors and the formation drawing block.

Parameters:
INITIAL_X, 60, start top-left X in pixels
INITIAL_Y, 20, start top-left Y in pixels
X_SPEED, 30, initial horizontal speed in 1/64 pixel per frame (positive = right)
OBJECT_WIDTH_X, 512, formation width in pixels
OBJECT_HIGHT_Y, 256, formation height in pixels
SAFETY_MARGIN, 2, pixel margin to the screen border
DROP_STEP, 8, pixels dropped per edge reversal
SPEEDUP, 8, added to |Xspeed| per reversal, in 1/64 pixel per frame
MAX_X_SPEED, 256, saturation limit for |Xspeed|
BOTTOM_LINE, 440, Y pixel at which the formation counts as landed
HITS_TO_CLEAR, 32, missile-hit frames needed to clear the formation
FP_SHIFT, 6, fixed-point fraction bits (1/64 pixel)

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
startOfFrame  in  1  one-clock pulse per frame
restart  in  1  one-clock pulse; return to IDLE from any state
collisionPlayer  in  1  formation touches the player
collisionShield  in  1  formation touches a shield
collisionMissile  in  1  player missile hits the formation
collisionBorder  in  1  formation touches a screen border; qualifies HitEdgeCode
HitEdgeCode  in  4  edge flags {left,top,right,bottom}, bit3..bit0
topLeftX  out  11 signed  formation X in pixels (Xposition >>> FP_SHIFT)
topLeftY  out  11 signed  formation Y in pixels
hitCount  out  8  missile-hit frames since restart
endGame  out  1  level; landed or player/shield contact
formationCleared  out  1  level; hitCount reached HITS_TO_CLEAR

Behaviour:
- Reset (asynchronous, active-low):
  - State goes to IDLE.
  - Positions, speed, hitCount, flags and edge register are cleared.
  - topLeftX, topLeftY, endGame and formationCleared read 0.
- States: IDLE, MOVE, START_OF_FRAME, POSITION_CHANGE, POSITION_LIMITS, ENDGAME, CLEARED.
- IDLE:
  - Loads Xposition = INITIAL_X<<FP_SHIFT, Yposition = INITIAL_Y<<FP_SHIFT, Xspeed = X_SPEED.
  - Clears hitCount, endGame and formationCleared.
  - startOfFrame moves the FSM to MOVE.
- Collision latching: in MOVE, POSITION_CHANGE and POSITION_LIMITS, collision inputs OR into sticky flags.
  - playerFlag: collisionPlayer or collisionShield.
  - missileFlag: collisionMissile.
  - edgeReg[3:0]: HitEdgeCode, only when collisionBorder=1.
  - Collisions in any other state are ignored.
- MOVE: startOfFrame moves the FSM to START_OF_FRAME.
- START_OF_FRAME, in priority order:
  1. playerFlag or edgeReg[0] → ENDGAME.
  2. missileFlag → hitCount+1 (one per frame, however many hits). If the new count equals HITS_TO_CLEAR → CLEARED.
  3. Reversal: edgeReg[3]&Xspeed<0 or edgeReg[1]&Xspeed>0 → Xspeed negated; pending drop = DROP_STEP. Left and right both set → no reversal, no drop.
  4. Otherwise → POSITION_CHANGE.
  - All flags clear in this cycle.
- POSITION_CHANGE:
  - Xposition += Xspeed.
  - Yposition += drop<<FP_SHIFT; pending drop cleared.
- POSITION_LIMITS:
  - Clamps X to [SAFETY_MARGIN, 639-SAFETY_MARGIN-OBJECT_WIDTH_X] pixels, both in fixed point.
  - If (Yposition>>>FP_SHIFT)+OBJECT_HIGHT_Y >= BOTTOM_LINE → ENDGAME; else → MOVE.
- Latency: new position is visible on topLeftX/Y 3 clocks after the startOfFrame pulse.
- ENDGAME: endGame=1; position frozen; restart → IDLE.
- CLEARED: formationCleared=1; position frozen; restart → IDLE.
- restart has priority over every transition, including same-cycle startOfFrame.
- Arithmetic:
  - Positions and speeds are 32-bit signed.
  - hitCount saturates at 255.
  - Division uses an arithmetic shift, so negative X rounds toward −inf.

Optional Feature:
MONSTER_SPEEDUP_EN
- Defined: on each reversal the new |Xspeed| = min(|old|+SPEEDUP, MAX_X_SPEED), sign reversed.
- Undefined: |Xspeed| stays at X_SPEED forever; SPEEDUP and MAX_X_SPEED are unused.

Test Plan:
1. Reset, then 3 startOfFrame pulses with no collisions → Xposition 3840→3930; topLeftX=61, topLeftY=20, endGame=0.
2. Xposition=3900, Xspeed=+30; collisionBorder with HitEdgeCode=0010, then startOfFrame → EN: Xspeed=−38, X=3862, topLeftX=60, topLeftY=28. Not EN: Xspeed=−30.
3. collisionShield pulse, then startOfFrame → endGame=1 from START_OF_FRAME+1; topLeftX/Y frozen for 10 frames; restart → topLeftX=60, topLeftY=20, endGame=0.
4. 32 frames with 3 missile pulses each → hitCount=32, formationCleared=1; later collisions ignored.
5. Repeated right/left border hits from Y=20 → topLeftY=188 after the 21st drop; endGame=1 and MOVE is not re-entered.
6. Assert resetN low mid-POSITION_CHANGE with hitCount=5 → all outputs 0 immediately; after release and startOfFrame, starts from (60,20) with hitCount=0.
